mod_mult: RTL and testbench

- Parametrised modular multiplier. Computes (a*b) mod m, or (a*a) mod m in square mode.
- Uses an interleaved MSB-first shift-add-reduce loop: one multiplier bit per cycle, no 2*WIDTH intermediate, no separate modulus block.
- Building block for the modular-exponentiation engine: square and multiply steps issue back-to-back through one instance.

---
 rtl/mod_arith_pkg.sv | 22 ++
 rtl/mod_mult_step.sv | 40 ++++
 rtl/mod_mult.sv | 157 +++++++++++++++
 tb/tb_mod_mult.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mod_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mod_arith_pkg
// Description : Shared types for the modular-arithmetic blocks: FSM state
//               encoding and operating mode of the modular multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package mod_arith_pkg;

    // Two-bit encoding leaves room for additional states in later variants.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1
    } mm_state_t;

    typedef enum logic {
        MM_MULT   = 1'b0,
        MM_SQUARE = 1'b1
    } mm_mode_t;

endpackage : mod_arith_pkg
`default_nettype wire

// File: rtl/mod_mult_step.sv
`default_nettype none
// ============================================================================
// Module      : mod_mult_step
// Description : One iteration of the MSB-first interleaved modular multiply:
//               acc_out = (2*acc_in + bit_in*a_in) mod m_in, with each of the
//               two additions followed by a single conditional subtraction.
//               Purely combinational; shared with the radix-4 variant.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_mult_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   acc_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] m_in,
    input  logic             bit_in,
    output logic [WIDTH:0]   acc_out
);

    logic [WIDTH:0] w_m_ext;
    logic [WIDTH:0] w_dbl;
    logic [WIDTH:0] w_sum;

    // Double, reduce, conditionally add a, reduce. With acc < m and a < m every
    // intermediate stays below 2m, which fits in WIDTH+1 bits.
    always_comb begin
        w_m_ext = {1'b0, m_in};
        w_dbl   = acc_in << 1;
        if (w_dbl >= w_m_ext) begin
            w_dbl = w_dbl - w_m_ext;
        end
        w_sum = w_dbl + (bit_in ? {1'b0, a_in} : '0);
        if (w_sum >= w_m_ext) begin
            w_sum = w_sum - w_m_ext;
        end
        acc_out = w_sum;
    end

endmodule : mod_mult_step
`default_nettype wire

// File: rtl/mod_mult.sv
`default_nettype none
// ============================================================================
// Module      : mod_mult
// Description : Parametrised modular multiplier, (a*b) mod m or (a*a) mod m.
//               Processes one multiplier bit per cycle MSB-first through
//               mod_mult_step; result appears WIDTH cycles after acceptance.
//               Optional macro MOD_MULT_ZERO_CHECK_EN adds error_out and
//               rejects a zero modulus with an immediate error completion.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_mult
    import mod_arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             ready_in,
    input  logic             mode_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] modulus_in,
    output logic [WIDTH-1:0] product_out,
    output logic             busy_out,
    output logic             valid_out
`ifdef MOD_MULT_ZERO_CHECK_EN
    ,
    output logic             error_out
`endif
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

    mm_state_t        state_q,   state_d;
    logic [WIDTH:0]   acc_q,     acc_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic [WIDTH-1:0] m_q,       m_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic             busy_q,    busy_d;
    logic             valid_q,   valid_d;
`ifdef MOD_MULT_ZERO_CHECK_EN
    logic             error_q,   error_d;
    logic             pend_q,    pend_d;
`endif

    logic [WIDTH:0]   w_step_acc;

    mod_mult_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_in  (acc_q),
        .a_in    (a_q),
        .m_in    (m_q),
        .bit_in  (b_q[cnt_q]),
        .acc_out (w_step_acc)
    );

    // Next-state and datapath control; pulses default low, everything else holds.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        m_d       = m_q;
        product_d = product_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
`ifdef MOD_MULT_ZERO_CHECK_EN
        error_d   = 1'b0;
        pend_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
`ifdef MOD_MULT_ZERO_CHECK_EN
                if (pend_q) begin
                    // Zero-modulus request accepted last edge: report it now.
                    product_d = '0;
                    valid_d   = 1'b1;
                    error_d   = 1'b1;
                end else if (ready_in && (modulus_in == '0)) begin
                    pend_d = 1'b1;
                end else
`endif
                if (ready_in) begin
                    a_d     = a_in;
                    b_d     = (mm_mode_t'(mode_in) == MM_SQUARE) ? a_in : b_in;
                    m_d     = modulus_in;
                    acc_d   = '0;
                    cnt_d   = c_CNT_LAST;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = w_step_acc;
                if (cnt_q == '0) begin
                    product_d = w_step_acc[WIDTH-1:0];
                    busy_d    = 1'b0;
                    valid_d   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            m_q       <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
`ifdef MOD_MULT_ZERO_CHECK_EN
            error_q   <= 1'b0;
            pend_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            m_q       <= m_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
`ifdef MOD_MULT_ZERO_CHECK_EN
            error_q   <= error_d;
            pend_q    <= pend_d;
`endif
        end
    end

    assign product_out = product_q;
    assign busy_out    = busy_q;
    assign valid_out   = valid_q;
`ifdef MOD_MULT_ZERO_CHECK_EN
    assign error_out   = error_q;
`endif

endmodule : mod_mult
`default_nettype wire

// File: tb/tb_mod_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_mult
// Description : Directed self-checking bench for mod_mult at WIDTH=16, plus a
//               short run of random operands against an integer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_mult;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             ready;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] product;
    logic             busy;
    logic             valid;
`ifdef MOD_MULT_ZERO_CHECK_EN
    logic             error;
`endif

    int passed = 0;
    int total  = 0;
    int failed = 0;

    mod_mult #(
        .WIDTH (WIDTH)
    ) dut (
        .clk_in      (clk),
        .rst_in      (rst),
        .ready_in    (ready),
        .mode_in     (mode),
        .a_in        (a),
        .b_in        (b),
        .modulus_in  (m),
        .product_out (product),
        .busy_out    (busy),
        .valid_out   (valid)
`ifdef MOD_MULT_ZERO_CHECK_EN
        ,
        .error_out   (error)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble the inputs after acceptance, wait for the
    // result and check latency, product and the handshake around it.
    task automatic run_op(input string tag, input logic md, input logic [WIDTH-1:0] ia,
                          input logic [WIDTH-1:0] ib, input logic [WIDTH-1:0] im,
                          input logic [WIDTH-1:0] exp);
        int lat;
        @(negedge clk);
        ready = 1'b1; mode = md; a = ia; b = ib; m = im;
        @(posedge clk); #1;
        ready = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); m = WIDTH'($urandom); mode = ~md;
        chk({tag, "_busy_rise"}, busy, 1'b1);
        lat = 0;
        while (!valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, WIDTH);
        chk({tag, "_product"}, product, exp);
        chk({tag, "_busy_fall"}, busy, 1'b0);
`ifdef MOD_MULT_ZERO_CHECK_EN
        chk({tag, "_error"}, error, 1'b0);
`endif
        @(posedge clk); #1;
        chk({tag, "_valid_pulse"}, valid, 1'b0);
    endtask

    logic [WIDTH-1:0] ex_a [3] = '{16'd7,  16'd12, 16'd100};
    logic [WIDTH-1:0] ex_b [3] = '{16'd5,  16'd0,  16'd200};
    logic [WIDTH-1:0] ex_m [3] = '{16'd13, 16'd13, 16'd251};
    logic             ex_md[3] = '{1'b0,   1'b1,   1'b0};
    logic [WIDTH-1:0] ex_p [3] = '{16'd9,  16'd1,  16'd171};

    initial begin
        int lat;
        int extra;
        longint unsigned ra, rb, rm;
        logic            rmd;
        rst = 1'b1; ready = 1'b0; mode = 1'b0; a = '0; b = '0; m = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_product", product, 0);
        chk("reset_busy", busy, 0);
        chk("reset_valid", valid, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        run_op("mul_7_5_13",   1'b0, 16'd7,     16'd5,     16'd13,    16'd9);
        run_op("sq_12_13",     1'b1, 16'd12,    16'hFFFF,  16'd13,    16'd1);
        run_op("mul_mmax",     1'b0, 16'd65520, 16'd65520, 16'd65521, 16'd1);
        run_op("mod_one",      1'b0, 16'd0,     16'd0,     16'd1,     16'd0);
        run_op("a_zero",       1'b0, 16'd0,     16'd5,     16'd13,    16'd0);
        run_op("mul_1000_3000",1'b0, 16'd1000,  16'd3000,  16'd65521, 16'd51555);

        // Back-to-back: ready_in held high; next operand set presented during RUN
        @(negedge clk);
        ready = 1'b1; mode = ex_md[0]; a = ex_a[0]; b = ex_b[0]; m = ex_m[0];
        @(posedge clk); #1;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("b2b%0d_busy_rise", j), busy, 1'b1);
            chk($sformatf("b2b%0d_valid_low", j), valid, 1'b0);
            if (j < 2) begin
                mode = ex_md[j+1]; a = ex_a[j+1]; b = ex_b[j+1]; m = ex_m[j+1];
            end
            lat = 0;
            while (!valid && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            chk($sformatf("b2b%0d_latency", j), lat, WIDTH);
            chk($sformatf("b2b%0d_product", j), product, ex_p[j]);
            chk($sformatf("b2b%0d_busy_fall", j), busy, 1'b0);
            if (j == 2) ready = 1'b0;
            @(posedge clk); #1;
        end
        extra = 0;
        repeat (20) begin
            if (valid || busy) extra++;
            @(posedge clk); #1;
        end
        chk("b2b_no_extra", extra, 0);

        // Reset at edge k+8 of an operation
        @(negedge clk);
        ready = 1'b1; mode = 1'b0; a = 16'd7; b = 16'd5; m = 16'd13;
        @(posedge clk); #1;
        ready = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_product", product, 0);
        extra = 0;
        repeat (20) begin
            if (valid) extra++;
            @(posedge clk); #1;
        end
        chk("rst_no_valid", extra, 0);
        run_op("after_rst", 1'b0, 16'd100, 16'd200, 16'd251, 16'd171);

`ifdef MOD_MULT_ZERO_CHECK_EN
        // Zero modulus: error completion one edge after acceptance
        @(negedge clk);
        ready = 1'b1; mode = 1'b0; a = 16'd3; b = 16'd4; m = 16'd0;
        @(posedge clk); #1;
        ready = 1'b0;
        chk("zero_busy_k", busy, 0);
        @(posedge clk); #1;
        chk("zero_valid", valid, 1'b1);
        chk("zero_error", error, 1'b1);
        chk("zero_product", product, 0);
        chk("zero_busy", busy, 0);
        @(posedge clk); #1;
        chk("zero_pulse_end", {30'd0, valid, error}, 0);
        run_op("after_zero", 1'b0, 16'd7, 16'd5, 16'd13, 16'd9);
`endif

        // Random operands against an integer model
        for (int i = 0; i < 40; i++) begin
            rm  = longint'($urandom_range(65535, 1));
            ra  = longint'($urandom) % rm;
            rb  = longint'($urandom) % rm;
            rmd = 1'($urandom);
            run_op($sformatf("rnd%0d", i), rmd, WIDTH'(ra), WIDTH'(rb), WIDTH'(rm),
                   WIDTH'(((rmd ? ra : rb) * ra) % rm));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_mod_mult
`default_nettype wire
